// File: rtl/axis_fifo.sv
// Synchronous AXI-Stream FIFO with first-word-fall-through output.
// Tracks stored beats and stored complete packets (tlast beats).
module axis_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          arstn_i,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic [$clog2(FIFO_DEPTH):0]   pkt_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [PW-1:0]       count_q, pkt_cnt_q;
  logic [DATA_WIDTH:0] head;
  logic                empty, full;
  logic                wr_en, rd_en;
  logic                wr_last, rd_last;

  // Handshake: a beat transfers on a rising edge where valid and ready are
  // both 1; ready is derived from registered pointers only, never from the
  // opposite side's valid/ready, so a read cannot free a slot for a write
  // in the same cycle.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign s_axis_tready = !full;
  assign m_axis_tvalid = !empty;

  assign wr_en = s_axis_tvalid && !full;
  assign rd_en = m_axis_tready && !empty;

  assign head         = mem[rd_ptr[AW-1:0]];
  assign m_axis_tdata = head[DATA_WIDTH-1:0];
  assign m_axis_tlast = head[DATA_WIDTH];

  assign wr_last = wr_en && s_axis_tlast;
  assign rd_last = rd_en && head[DATA_WIDTH];

  assign count_o   = count_q;
  assign pkt_cnt_o = pkt_cnt_q;

  // Storage is deliberately not reset; output data is don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      count_q <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + PW'(1);
        2'b01:   count_q <= count_q - PW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Packet count follows the same rule, restricted to tlast beats.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      pkt_cnt_q <= '0;
    end else begin
      case ({wr_last, rd_last})
        2'b10:   pkt_cnt_q <= pkt_cnt_q + PW'(1);
        2'b01:   pkt_cnt_q <= pkt_cnt_q - PW'(1);
        default: pkt_cnt_q <= pkt_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_fifo.sv
// Directed bench for axis_fifo: driver tasks push expected beats into a
// queue, a negedge monitor pops and compares every beat the DUT hands out.
module tb_axis_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [CW-1:0] count_o;
  logic [CW-1:0] pkt_cnt_o;

  logic [DW:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  axis_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .count_o       (count_o),
    .pkt_cnt_o     (pkt_cnt_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one beat for one cycle; acc reports whether it was taken.
  task automatic drive_beat(input logic [DW-1:0] data, input logic last, output logic acc);
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    @(negedge clk_i);
    acc = s_axis_tready;
    if (acc) exp_q.push_back({last, data});
    next_cycle();
    s_axis_tvalid = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clk_i) begin
    if (arstn_i === 1'b1 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got 0x%0h with no beat expected at %0t",
                 {m_axis_tlast, m_axis_tdata}, $time);
      end else begin
        check("m_axis_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic acc;
    int   wait_cnt;
    arstn_i       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;

    // Reset state visible before any clock edge.
    #1;
    check("rst_tvalid_pre", 32'(m_axis_tvalid), 32'd0);
    check("rst_tready_pre", 32'(s_axis_tready), 32'd1);
    check("rst_count_pre", 32'(count_o), 32'd0);
    check("rst_pkt_pre", 32'(pkt_cnt_o), 32'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    arstn_i = 1'b1;
    next_cycle();

    // Single beat.
    drive_beat(8'hA5, 1'b1, acc);
    check("single_acc", 32'(acc), 32'd1);
    @(negedge clk_i);
    check("single_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("single_tdata", 32'(m_axis_tdata), 32'hA5);
    check("single_tlast", 32'(m_axis_tlast), 32'd1);
    check("single_count", 32'(count_o), 32'd1);
    check("single_pkt", 32'(pkt_cnt_o), 32'd1);
    next_cycle();
    m_axis_tready = 1'b1;
    next_cycle();
    m_axis_tready = 1'b0;
    @(negedge clk_i);
    check("single_count_after", 32'(count_o), 32'd0);
    check("single_pkt_after", 32'(pkt_cnt_o), 32'd0);
    check("single_tvalid_after", 32'(m_axis_tvalid), 32'd0);
    next_cycle();

    // Fill to full; tlast on 0x03, 0x07, 0x0B, 0x0F.
    for (int i = 0; i < 16; i++) begin
      drive_beat(8'(i), (i % 4) == 3, acc);
      check("fill_acc", 32'(acc), 32'd1);
    end
    @(negedge clk_i);
    check("full_tready", 32'(s_axis_tready), 32'd0);
    check("full_count", 32'(count_o), 32'd16);
    check("full_pkt", 32'(pkt_cnt_o), 32'd4);
    next_cycle();
    drive_beat(8'hEE, 1'b0, acc);
    check("full_17th_refused", 32'(acc), 32'd0);
    check("full_count_hold", 32'(count_o), 32'd16);

    // Full with a read pending: read happens (0x00), write 0x77 refused.
    m_axis_tready = 1'b1;
    drive_beat(8'h77, 1'b0, acc);
    m_axis_tready = 1'b0;
    check("fullrd_write_refused", 32'(acc), 32'd0);
    @(negedge clk_i);
    check("fullrd_count", 32'(count_o), 32'd15);
    check("fullrd_tready", 32'(s_axis_tready), 32'd1);
    check("fullrd_pkt", 32'(pkt_cnt_o), 32'd4);
    check("fullrd_head", 32'(m_axis_tdata), 32'h01);
    next_cycle();

    // Drain 0x01..0x0F in order.
    m_axis_tready = 1'b1;
    repeat (15) next_cycle();
    m_axis_tready = 1'b0;
    @(negedge clk_i);
    check("drain_count", 32'(count_o), 32'd0);
    check("drain_pkt", 32'(pkt_cnt_o), 32'd0);
    next_cycle();

    // Simultaneous access around count 8, crossing the index wrap.
    for (int i = 0; i < 8; i++) drive_beat(8'h20 + 8'(i), 1'b0, acc);
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_axis_tdata = 8'h28 + 8'(i);
      s_axis_tlast = (i % 5) == 4;
      @(negedge clk_i);
      check("simul_count", 32'(count_o), 32'd8);
      if (s_axis_tready) exp_q.push_back({s_axis_tlast, s_axis_tdata});
      next_cycle();
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    @(negedge clk_i);
    check("simul_count_end", 32'(count_o), 32'd8);
    check("simul_pkt_end", 32'(pkt_cnt_o), 32'd2);
    check("simul_head", 32'(m_axis_tdata), 32'h34);
    next_cycle();
    m_axis_tready = 1'b1;
    repeat (8) next_cycle();
    m_axis_tready = 1'b0;
    @(negedge clk_i);
    check("simul_drain_count", 32'(count_o), 32'd0);
    next_cycle();

    // Mid-operation asynchronous reset.
    drive_beat(8'h50, 1'b0, acc);
    drive_beat(8'h51, 1'b1, acc);
    drive_beat(8'h52, 1'b0, acc);
    drive_beat(8'h53, 1'b0, acc);
    drive_beat(8'h54, 1'b1, acc);
    @(negedge clk_i);
    check("midrst_count_before", 32'(count_o), 32'd5);
    check("midrst_pkt_before", 32'(pkt_cnt_o), 32'd2);
    #2;
    arstn_i = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_count", 32'(count_o), 32'd0);
    check("midrst_pkt", 32'(pkt_cnt_o), 32'd0);
    check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("midrst_tready", 32'(s_axis_tready), 32'd1);
    @(negedge clk_i);
    arstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    drive_beat(8'h3C, 1'b1, acc);
    check("postrst_acc", 32'(acc), 32'd1);
    @(negedge clk_i);
    check("postrst_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("postrst_tdata", 32'(m_axis_tdata), 32'h3C);
    check("postrst_count", 32'(count_o), 32'd1);
    next_cycle();
    m_axis_tready = 1'b1;

    // Bounded wait for the scoreboard to empty.
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 50) begin
      next_cycle();
      wait_cnt++;
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    m_axis_tready = 1'b0;
    @(negedge clk_i);
    check("final_count", 32'(count_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
